enabled_item_collector: RTL

ENABLED_ITEM_COLLECTOR -- requirements
Module: enabled_item_collector

---
 rtl/enabled_item_pkg.sv | 18 +
 rtl/enabled_item_collector_rotated_prefix_mask.sv | 53 +++++
 rtl/enabled_item_collector.sv | 108 ++++++++++
 3 files changed

// File: rtl/enabled_item_pkg.sv
// Shared widths and typedefs for the enabled-item collector.
// Slot-id and count widths are derived from the slot count.
package enabled_item_pkg;

  localparam int unsigned DEF_ITEM_NUM = 8;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  typedef logic [id_w(DEF_ITEM_NUM)-1:0]  slot_id_t;
  typedef logic [cnt_w(DEF_ITEM_NUM)-1:0] cnt_t;

endpackage

// File: rtl/enabled_item_collector_rotated_prefix_mask.sv
// Oldest-first clear mask: rotate by head, take first N set bits,
// unrotate, and report the last slot taken. Purely combinational.
module rotated_prefix_mask
  import enabled_item_pkg::*;
#(
  parameter int ITEM_NUM = 8
) (
  input  logic [ITEM_NUM-1:0]           i_seq,
  input  logic [id_w(ITEM_NUM)-1:0]     i_start,
  input  logic [cnt_w(ITEM_NUM)-1:0]    i_num,
  output logic [ITEM_NUM-1:0]           o_clr,
  output logic [id_w(ITEM_NUM)-1:0]     o_last
);

  localparam int IW = id_w(ITEM_NUM);
  localparam int CW = cnt_w(ITEM_NUM);

  logic [ITEM_NUM-1:0] w_rot;
  logic [ITEM_NUM-1:0] w_sel;
  logic [CW-1:0]       w_run;

  // rotate so that the head slot lands at position 0
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < ITEM_NUM; i++)
      w_rot[i] = i_seq[i_start + IW'(i)];
  end

  // keep set bits while fewer than i_num have been taken
  always_comb begin
    w_sel = '0;
    w_run = '0;
    for (int i = 0; i < ITEM_NUM; i++) begin
      if (w_rot[i] && (w_run < i_num)) begin
        w_sel[i] = 1'b1;
        w_run    = w_run + CW'(1);
      end
    end
  end

  // map the selection back to slot order and find the last one
  always_comb begin
    o_clr  = '0;
    o_last = i_start;
    for (int i = 0; i < ITEM_NUM; i++) begin
      if (w_sel[i]) begin
        o_clr[i_start + IW'(i)] = 1'b1;
        o_last                  = i_start + IW'(i);
      end
    end
  end

endmodule

// File: rtl/enabled_item_collector.sv
// Slot-enable collector: multi-port set, oldest-first bulk consume.
// Define ENABLED_ITEM_COLLECTOR_ERROR_CHECK_EN for the sticky error flag.
module enabled_item_collector
  import enabled_item_pkg::*;
#(
  parameter int ITEM_NUM = 8,
  parameter int PORT_NUM = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORT_NUM-1:0]                   set_valid,
  input  logic [PORT_NUM-1:0][id_w(ITEM_NUM)-1:0] set_id,
  input  logic                                  consume_valid,
  input  logic [cnt_w(ITEM_NUM)-1:0]            consume_num,
  output logic                                  consume_ready,
  output logic [ITEM_NUM-1:0]                   seq,
  output logic [id_w(ITEM_NUM)-1:0]             start_pos,
  output logic [cnt_w(ITEM_NUM)-1:0]            enabled_num,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  error
);

  localparam int IW = id_w(ITEM_NUM);
  localparam int CW = cnt_w(ITEM_NUM);

  logic [ITEM_NUM-1:0] r_seq;
  logic [IW-1:0]       r_start;
  logic [CW-1:0]       r_cnt;

  logic [ITEM_NUM-1:0] w_set;
  logic [ITEM_NUM-1:0] w_pm_clr;
  logic [ITEM_NUM-1:0] w_clr;
  logic [ITEM_NUM-1:0] w_nseq;
  logic [IW-1:0]       w_last;
  logic [IW-1:0]       w_nstart;
  logic [CW-1:0]       w_ncnt;
  logic                w_fire;

  rotated_prefix_mask #(
    .ITEM_NUM (ITEM_NUM)
  ) u_pm (
    .i_seq   (r_seq),
    .i_start (r_start),
    .i_num   (consume_num),
    .o_clr   (w_pm_clr),
    .o_last  (w_last)
  );

  // merge all set ports into one slot mask
  always_comb begin
    w_set = '0;
    for (int p = 0; p < PORT_NUM; p++)
      if (set_valid[p]) w_set[set_id[p]] = 1'b1;
  end

  assign consume_ready = (consume_num <= r_cnt);
  assign w_fire = consume_valid & consume_ready
                & (consume_num != '0);
  assign w_clr  = w_fire ? w_pm_clr : '0;
  assign w_nseq = (r_seq & ~w_clr) | w_set;
  assign w_nstart = w_fire ? (w_last + IW'(1)) : r_start;

  // popcount of the next mask
  always_comb begin
    w_ncnt = '0;
    for (int i = 0; i < ITEM_NUM; i++)
      w_ncnt = w_ncnt + CW'(w_nseq[i]);
  end

  // mask, head and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq   <= '0;
      r_start <= '0;
      r_cnt   <= '0;
    end else begin
      r_seq   <= w_nseq;
      r_start <= w_nstart;
      r_cnt   <= w_ncnt;
    end
  end

  assign seq         = r_seq;
  assign start_pos   = r_start;
  assign enabled_num = r_cnt;
  assign full        = (r_cnt == CW'(ITEM_NUM));
  assign empty       = (r_cnt == '0);

`ifdef ENABLED_ITEM_COLLECTOR_ERROR_CHECK_EN
  logic r_error;
  logic w_err_hit;

  assign w_err_hit = (|(w_set & r_seq & ~w_clr))
                   | (consume_valid & ~consume_ready);

  // sticky protocol-error flag
  always_ff @(posedge clk) begin
    if (rst)            r_error <= 1'b0;
    else if (w_err_hit) r_error <= 1'b1;
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule
